// File: rtl/countdown_timer_mmss_if.sv
// Control and display bundle for the MM:SS countdown timer.
// The master drives the controls; the timer slave drives the digits and status.
interface countdown_timer_mmss_if;
   logic       en;
   logic       load;
   logic [3:0] load_min_msd;
   logic [3:0] load_min_lsd;
   logic [3:0] load_sec_msd;
   logic [3:0] load_sec_lsd;
   logic       start;
   logic       stop;
   logic [3:0] min_msd;
   logic [3:0] min_lsd;
   logic [3:0] sec_msd;
   logic [3:0] sec_lsd;
   logic       running;
   logic       zero;
   logic       done;
   logic       alarm;

   modport master (
      output en, load, start, stop,
      output load_min_msd, load_min_lsd,
      output load_sec_msd, load_sec_lsd,
      input  min_msd, min_lsd, sec_msd, sec_lsd,
      input  running, zero, done, alarm
   );

   modport slave (
      input  en, load, start, stop,
      input  load_min_msd, load_min_lsd,
      input  load_sec_msd, load_sec_lsd,
      output min_msd, min_lsd, sec_msd, sec_lsd,
      output running, zero, done, alarm
   );
endinterface

// File: rtl/countdown_timer_mmss.sv
// BCD MM:SS countdown timer with load, pause, done pulse and timed alarm.
// Counts down one second per en tick while running and stops at 00:00.
module countdown_timer_mmss #(
   parameter int MIN_MSD_MAX = 5,
   parameter int ALARM_TICKS = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   countdown_timer_mmss_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      EXPIRED
   } state_t;

   state_t     state;
   logic [3:0] mm_t, mm_u, ss_t, ss_u;
   logic [3:0] alarm_cnt;
   logic       running_q, done_q, alarm_q;

   logic [3:0] ld_mm_t, ld_mm_u, ld_ss_t, ld_ss_u;
   logic [3:0] dec_mm_t, dec_mm_u, dec_ss_t, dec_ss_u;
   logic       is_zero, is_last;

   localparam logic [3:0] MM_T_MAX = 4'(MIN_MSD_MAX);
   localparam logic [3:0] A_TICKS  = 4'(ALARM_TICKS);

   // Clamp incoming digits so the counter never holds non-BCD or out-of-range values.
   always_comb begin
      ld_mm_t = (bus.load_min_msd > MM_T_MAX) ? MM_T_MAX : bus.load_min_msd;
      ld_mm_u = (bus.load_min_lsd > 4'd9) ? 4'd9 : bus.load_min_lsd;
      ld_ss_t = (bus.load_sec_msd > 4'd5) ? 4'd5 : bus.load_sec_msd;
      ld_ss_u = (bus.load_sec_lsd > 4'd9) ? 4'd9 : bus.load_sec_lsd;
   end

   // One-second decrement with borrow ripple; holds at 00:00.
   always_comb begin
      dec_mm_t = mm_t;
      dec_mm_u = mm_u;
      dec_ss_t = ss_t;
      dec_ss_u = ss_u;
      if (!is_zero) begin
         if (ss_u != 4'd0) begin
            dec_ss_u = ss_u - 4'd1;
         end else begin
            dec_ss_u = 4'd9;
            if (ss_t != 4'd0) begin
               dec_ss_t = ss_t - 4'd1;
            end else begin
               dec_ss_t = 4'd5;
               if (mm_u != 4'd0) begin
                  dec_mm_u = mm_u - 4'd1;
               end else begin
                  dec_mm_u = 4'd9;
                  dec_mm_t = mm_t - 4'd1;
               end
            end
         end
      end
   end

   assign is_zero = (mm_t == 4'd0) && (mm_u == 4'd0) &&
                    (ss_t == 4'd0) && (ss_u == 4'd0);
   assign is_last = (mm_t == 4'd0) && (mm_u == 4'd0) &&
                    (ss_t == 4'd0) && (ss_u == 4'd1);

   // Control FSM: load > stop > start > en, all outputs registered except zero.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state     <= IDLE;
         mm_t      <= 4'd0;
         mm_u      <= 4'd0;
         ss_t      <= 4'd0;
         ss_u      <= 4'd0;
         alarm_cnt <= 4'd0;
         running_q <= 1'b0;
         done_q    <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         done_q <= 1'b0;
         if (bus.load) begin
            mm_t      <= ld_mm_t;
            mm_u      <= ld_mm_u;
            ss_t      <= ld_ss_t;
            ss_u      <= ld_ss_u;
            state     <= IDLE;
            running_q <= 1'b0;
            alarm_q   <= 1'b0;
            alarm_cnt <= 4'd0;
         end else begin
            unique case (state)
               IDLE, PAUSE: begin
                  if (!bus.stop && bus.start && !is_zero) begin
                     state     <= RUN;
                     running_q <= 1'b1;
                  end
               end
               RUN: begin
                  if (bus.stop) begin
                     state     <= PAUSE;
                     running_q <= 1'b0;
                  end else if (bus.en) begin
                     if (is_last) begin
                        state     <= EXPIRED;
                        running_q <= 1'b0;
                        done_q    <= 1'b1;
                        alarm_q   <= 1'b1;
                        alarm_cnt <= A_TICKS;
                     end
                     mm_t <= dec_mm_t;
                     mm_u <= dec_mm_u;
                     ss_t <= dec_ss_t;
                     ss_u <= dec_ss_u;
                  end
               end
               EXPIRED: begin
                  if (bus.stop) begin
                     state     <= IDLE;
                     alarm_q   <= 1'b0;
                     alarm_cnt <= 4'd0;
                  end else if (bus.en) begin
                     if (alarm_cnt <= 4'd1) begin
                        state     <= IDLE;
                        alarm_q   <= 1'b0;
                        alarm_cnt <= 4'd0;
                     end else begin
                        alarm_cnt <= alarm_cnt - 4'd1;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.min_msd = mm_t;
   assign bus.min_lsd = mm_u;
   assign bus.sec_msd = ss_t;
   assign bus.sec_lsd = ss_u;
   assign bus.running = running_q;
   assign bus.zero    = is_zero;
   assign bus.done    = done_q;
   assign bus.alarm   = alarm_q;

endmodule
